axi_dma_rd: RTL and testbench

AXI_DMA_RD -- requirements
Module: axi_dma_rd

---
 rtl/axi_dma_rd_if.sv | 34 +++
 rtl/axi_dma_rd.sv | 132 +++++++++++++
 tb/tb_axi_dma_rd.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_dma_rd_if.sv
// ---------------------------------------------------------------------------
// axi_dma_rd_if
// AXI4 read-address and read-data channels used by the DMA read engine.
//   master modport : DMA side (drives AR channel, RREADY)
//   slave modport  : memory / interconnect side (drives ARREADY, R channel)
// ---------------------------------------------------------------------------
interface axi_dma_rd_if #(
    parameter int AXI_WIDTH_AD = 32,
    parameter int AXI_WIDTH_DA = 32
);
    // read-address channel
    logic                    M_ARVALID;
    logic                    M_ARREADY;
    logic [AXI_WIDTH_AD-1:0] M_ARADDR;
    logic [7:0]              M_ARLEN;
    logic [2:0]              M_ARSIZE;
    logic [1:0]              M_ARBURST;
    // read-data channel
    logic                    M_RVALID;
    logic                    M_RREADY;
    logic [AXI_WIDTH_DA-1:0] M_RDATA;
    logic [1:0]              M_RRESP;
    logic                    M_RLAST;

    modport master (
        output M_ARVALID, M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST, M_RREADY,
        input  M_ARREADY, M_RVALID, M_RDATA, M_RRESP, M_RLAST
    );

    modport slave (
        input  M_ARVALID, M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST, M_RREADY,
        output M_ARREADY, M_RVALID, M_RDATA, M_RRESP, M_RLAST
    );
endinterface

// File: rtl/axi_dma_rd.sv
// ---------------------------------------------------------------------------
// axi_dma_rd
// AXI4 read engine for a DMA controller. A start pulse loads a word-aligned
// byte address and a beat count; the engine issues INCR bursts (one at a
// time, never crossing a 4 KB page) and streams the returned beats straight
// through to a downstream buffer with zero latency.
//   clk, rst        : single clock, synchronous active-high reset
//   i_ctrl_read     : one-cycle start pulse (accepted only in IDLE)
//   i_read_addr     : start byte address (word aligned)
//   i_num_trans     : number of 4-byte beats to read
//   o_read_done     : one-cycle completion pulse
//   o_read_err      : sticky error (bad RRESP or RLAST misplacement)
//   m_axi           : AXI4 AR/R channels (master modport)
//   o_rd_data/o_rd_valid/i_rd_ready : downstream stream
// ---------------------------------------------------------------------------
module axi_dma_rd #(
    parameter int AXI_WIDTH_AD = 32,
    parameter int AXI_WIDTH_DA = 32,
    parameter int BIT_TRANS    = 18,
    parameter int MAX_BURST    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_ctrl_read,
    input  logic [AXI_WIDTH_AD-1:0] i_read_addr,
    input  logic [BIT_TRANS-1:0]    i_num_trans,
    output logic                    o_read_done,
    output logic                    o_read_err,
    axi_dma_rd_if.master            m_axi,
    output logic [AXI_WIDTH_DA-1:0] o_rd_data,
    output logic                    o_rd_valid,
    input  logic                    i_rd_ready
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AR   = 2'd1;
    localparam logic [1:0] S_R    = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // comparison width large enough for both the beat count and a page's beats
    localparam int CW = (BIT_TRANS > 13) ? BIT_TRANS : 13;

    logic [1:0]              r_state;
    logic [AXI_WIDTH_AD-1:0] r_cur_addr;
    logic [BIT_TRANS-1:0]    r_remain;
    logic [8:0]              r_beat_cnt;
    logic [8:0]              r_blen;
    logic                    r_err;

    logic [12:0]             w_page_bytes;
    logic [CW-1:0]           w_page_beats;
    logic [CW-1:0]           w_rem;
    logic [CW-1:0]           w_lim;
    logic [8:0]              w_blen;
    logic                    w_beat;
    logic                    w_last;

    // Burst length for the next AR. cur_addr and remain are frozen while in
    // AR, so ARLEN derived from this stays stable until the handshake.
    always_comb begin
        w_page_bytes = 13'h1000 - {1'b0, r_cur_addr[11:0]};
        w_page_beats = CW'(w_page_bytes >> 2);
        w_rem        = CW'(r_remain);
        w_lim        = CW'(MAX_BURST);
        if (w_page_beats < w_lim) w_lim = w_page_beats;
        if (w_rem < w_lim)        w_lim = w_rem;
        w_blen       = w_lim[8:0];
    end

    assign w_beat = (r_state == S_R) && m_axi.M_RVALID && i_rd_ready;
    // the burst ends on our own count; RLAST is only checked against it
    assign w_last = (r_beat_cnt == (r_blen - 9'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cur_addr <= '0;
            r_remain   <= '0;
            r_beat_cnt <= '0;
            r_blen     <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_ctrl_read) begin
                        r_cur_addr <= i_read_addr;
                        r_remain   <= i_num_trans;
                        r_beat_cnt <= '0;
                        r_err      <= 1'b0;
                        r_state    <= (i_num_trans != '0) ? S_AR : S_DONE;
                    end
                end
                S_AR: begin
                    if (m_axi.M_ARREADY) begin
                        r_blen  <= w_blen;
                        r_state <= S_R;
                    end
                end
                S_R: begin
                    if (w_beat) begin
                        r_remain <= r_remain - BIT_TRANS'(1);
                        if ((m_axi.M_RRESP != 2'b00) || (m_axi.M_RLAST != w_last))
                            r_err <= 1'b1;
                        if (w_last) begin
                            r_beat_cnt <= '0;
                            r_cur_addr <= r_cur_addr + AXI_WIDTH_AD'({r_blen, 2'b00});
                            // remain is pre-decrement here: 1 means this was the final beat
                            r_state    <= (r_remain != BIT_TRANS'(1)) ? S_AR : S_DONE;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 9'd1;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign m_axi.M_ARVALID = (r_state == S_AR);
    assign m_axi.M_ARADDR  = r_cur_addr;
    assign m_axi.M_ARLEN   = 8'(w_blen - 9'd1);
    assign m_axi.M_ARSIZE  = 3'b010;
    assign m_axi.M_ARBURST = 2'b01;
    assign m_axi.M_RREADY  = (r_state == S_R) && i_rd_ready;

    assign o_rd_valid  = (r_state == S_R) && m_axi.M_RVALID;
    assign o_rd_data   = m_axi.M_RDATA;
    assign o_read_done = (r_state == S_DONE);
    assign o_read_err  = r_err;

endmodule

// File: tb/tb_axi_dma_rd.sv
module tb_axi_dma_rd;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BT = 18;
    localparam int MB = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ctrl = 1'b0;
    logic [AW-1:0] raddr = '0;
    logic [BT-1:0] ntrans = '0;
    logic          done, err, rdv;
    logic          rdr = 1'b0;
    logic [DW-1:0] rdd;

    always #5 clk = ~clk;

    axi_dma_rd_if #(.AXI_WIDTH_AD(AW), .AXI_WIDTH_DA(DW)) bus ();

    axi_dma_rd #(.AXI_WIDTH_AD(AW), .AXI_WIDTH_DA(DW), .BIT_TRANS(BT), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .i_ctrl_read(ctrl), .i_read_addr(raddr), .i_num_trans(ntrans),
        .o_read_done(done), .o_read_err(err),
        .m_axi(bus),
        .o_rd_data(rdd), .o_rd_valid(rdv), .i_rd_ready(rdr)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    // scoreboard queues
    logic [AW-1:0] exp_ar_addr[$];
    logic [7:0]    exp_ar_len[$];
    logic [DW-1:0] exp_r[$];
    int            exp_done_cyc[$];   // -1: cycle right after the last beat
    logic          exp_done_err[$];

    // slave model control
    logic stall = 1'b0;
    logic inj   = 1'b0;
    int   beat_glob = 0;
    int   beats_seen = 0;

    // handshake samples taken at negedge, consumed by the slave after posedge
    logic          hs_ar = 1'b0, hs_r = 1'b0;
    logic [AW-1:0] ar_a = '0;
    logic [7:0]    ar_l = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- AXI slave model ----------------
    logic          s_act = 1'b0;
    logic [AW-1:0] s_addr = '0;
    int            s_len = 0;
    int            s_idx = 0;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            s_act = 1'b0; s_idx = 0;
            bus.M_ARREADY = 1'b0; bus.M_RVALID = 1'b0; bus.M_RDATA = '0;
            bus.M_RRESP = 2'b00; bus.M_RLAST = 1'b0; rdr = 1'b0;
        end else begin
            if (hs_r && s_act) begin
                s_idx++; beat_glob++;
                if (s_idx > s_len) s_act = 1'b0;
            end
            if (hs_ar) begin
                s_act = 1'b1; s_addr = ar_a; s_len = int'(ar_l); s_idx = 0;
            end
            bus.M_ARREADY = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
            if (!s_act) bus.M_RVALID = 1'b0;
            else if (!(bus.M_RVALID && !hs_r)) bus.M_RVALID = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.M_RDATA = ~(s_addr + 32'(4 * s_idx));
            bus.M_RLAST = (s_idx == s_len) || (inj && beat_glob == 5);
            bus.M_RRESP = (inj && beat_glob == 3) ? 2'b10 : 2'b00;
            rdr = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // ---------------- monitor ----------------
    logic          p_arv = 1'b0, p_arr = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic [7:0]    p_len = '0;
    int            last_beat_cyc = 0;

    always @(negedge clk) begin
        hs_ar = bus.M_ARVALID && bus.M_ARREADY;
        ar_a  = bus.M_ARADDR;
        ar_l  = bus.M_ARLEN;
        hs_r  = bus.M_RVALID && bus.M_RREADY;
        if (rst) begin
            p_arv = 1'b0;
        end else begin
            if (p_arv && !p_arr) begin
                chk("ar_stall_valid", bus.M_ARVALID, 1'b1);
                chk("ar_stall_addr", bus.M_ARADDR, p_addr);
                chk("ar_stall_len", bus.M_ARLEN, p_len);
            end
            p_arv = bus.M_ARVALID; p_arr = bus.M_ARREADY;
            p_addr = bus.M_ARADDR; p_len = bus.M_ARLEN;
            if (hs_ar) begin
                if (exp_ar_addr.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL ar_unexpected: got AR addr %0h len %0d, none expected", ar_a, ar_l);
                end else begin
                    chk("ar_addr", ar_a, exp_ar_addr.pop_front());
                    chk("ar_len", ar_l, exp_ar_len.pop_front());
                    chk("ar_size_burst", {bus.M_ARSIZE, bus.M_ARBURST}, {3'b010, 2'b01});
                end
            end
            if (rdv && rdr) begin
                chk("r_passthru", {hs_r, rdd}, {1'b1, bus.M_RDATA});
                beats_seen++;
                last_beat_cyc = cyc;
                if (exp_r.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL r_unexpected: got beat %0h, none expected", rdd);
                end else begin
                    chk("r_data", rdd, exp_r.pop_front());
                end
            end
            if (done) begin
                if (exp_done_cyc.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL done_unexpected: got done at cycle %0d, none expected", cyc);
                end else begin
                    automatic int e = exp_done_cyc.pop_front();
                    chk("done_cycle", cyc, (e < 0) ? last_beat_cyc + 1 : e);
                    chk("done_err", err, exp_done_err.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic start(input logic [AW-1:0] a, input int n, input logic inj_i, input logic stl);
        stall = stl; inj = inj_i; beat_glob = 0;
        for (int i = 0; i < n; i++) exp_r.push_back(~(a + 32'(4 * i)));
        @(posedge clk); #1;
        ctrl = 1'b1; raddr = a; ntrans = BT'(n);
        exp_done_cyc.push_back((n == 0) ? cyc + 1 : -1);
        exp_done_err.push_back(inj_i);
        @(posedge clk); #1;
        ctrl = 1'b0;
    endtask

    task automatic exp_ar(input logic [AW-1:0] a, input logic [7:0] l);
        exp_ar_addr.push_back(a); exp_ar_len.push_back(l);
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 3000 && exp_done_cyc.size() != 0; i++) @(negedge clk);
        chk({nm, "_timeout"}, exp_done_cyc.size(), 0);
        chk({nm, "_ar_left"}, exp_ar_addr.size(), 0);
        chk({nm, "_r_left"}, exp_r.size(), 0);
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_outs"}, {bus.M_ARVALID, bus.M_RREADY, rdv, done, err}, 5'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // single aligned 16-beat burst
        exp_ar(32'h1000_0000, 8'd15);
        start(32'h1000_0000, 16, 1'b0, 1'b0);
        wait_idle("t16");

        // 40 beats split by MAX_BURST
        exp_ar(32'h0, 8'd15); exp_ar(32'h40, 8'd15); exp_ar(32'h80, 8'd7);
        start(32'h0, 40, 1'b0, 1'b0);
        wait_idle("t40");

        // 4 KB page split
        exp_ar(32'h0FF8, 8'd1); exp_ar(32'h1000, 8'd5);
        start(32'h0FF8, 8, 1'b0, 1'b0);
        wait_idle("t4k");

        // zero-length transfer: no AR, immediate done
        start(32'h0, 0, 1'b0, 1'b0);
        wait_idle("t0");

        // random stalls with a bad RRESP and an early RLAST
        exp_ar(32'h3000, 8'd15); exp_ar(32'h3040, 8'd3);
        start(32'h3000, 20, 1'b1, 1'b1);
        wait_idle("tstall");
        repeat (3) begin
            @(negedge clk);
            chk("err_sticky", err, 1'b1);
        end

        // abandon a burst with reset after 5 beats
        exp_ar(32'h5000, 8'd15);
        start(32'h5000, 16, 1'b0, 1'b0);
        @(negedge clk);
        chk("err_clear_on_start", err, 1'b0);
        begin
            automatic int base = beats_seen - ((exp_r.size() < 16) ? 16 - exp_r.size() : 0);
            for (int i = 0; i < 200 && beats_seen < base + 5; i++) @(negedge clk);
            chk("reset_wait_beats", beats_seen - base, 5);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        exp_r.delete(); exp_ar_addr.delete(); exp_ar_len.delete();
        exp_done_cyc.delete(); exp_done_err.delete();
        @(posedge clk);
        @(negedge clk);
        chk_reset_outs("midreset");
        @(posedge clk); #1;
        rst = 1'b0;
        exp_ar(32'h2000, 8'd3);
        start(32'h2000, 4, 1'b0, 1'b0);
        wait_idle("tpost");
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
